timer_preset: RTL
=================

Name: timer_preset

Overview:
- Time-entry and load controller: the initiator side of the countdown timer's load interface.
- Turns debounced push-button levels into a preset value and a one-cycle load strobe:
  - preset value on init_hr/init_min/init_sec;
  - load strobe on tm_en.
- Watches the timer's timer_done and raises an alarm indication.
- Sits between the board button debouncers and the timer module in the clock top level.

Parameters:
- MAX_HR, 23, highest hour value; hour field wraps MAX_HR <-> 0.
- ALARM_CYCLES, 10, clk cycles alarm stays high after timer_done when no button is pressed.
- REPEAT_DLY, 4, cycles inc/dec must be held before auto-repeat starts (feature only).
- REPEAT_RATE, 2, cycles between auto-repeat steps (feature only).

Ports:
- clk  in  1  system clock; same clock as the timer.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  debounced level; rising edge selects the next field.
- btn_inc  in  1  debounced level; rising edge increments the selected field.
- btn_dec  in  1  debounced level; rising edge decrements the selected field.
- btn_start  in  1  debounced level; rising edge launches the timer.
- timer_done  in  1  from timer; high when the countdown reaches zero.
- init_hr  out  5  preset hours, 0..MAX_HR.
- init_min  out  6  preset minutes, 0..59.
- init_sec  out  6  preset seconds, 0..59.
- tm_en  out  1  one-cycle load strobe to the timer.
- edit_field  out  2  0 = none, 1 = hr, 2 = min, 3 = sec.
- busy  out  1  high while the timer runs (state RUN).
- alarm  out  1  high in state ALARM.

Behaviour:
- Reset: all outputs 0, state IDLE. Button history registers reset to 1, so a button held through reset produces no edge.
- Edge detection: an edge is sample high with previous sample low. All edges are registered. An action is visible on outputs the cycle after the edge is sampled.
- States: IDLE, SET_HR, SET_MIN, SET_SEC, RUN, ALARM.
- Mode edge steps IDLE -> SET_HR -> SET_MIN -> SET_SEC -> IDLE. edit_field follows the state: 0 in IDLE/RUN/ALARM.
- Inc/dec act only in the SET_* states, on the selected field.
  - Inc: sec/min 59 -> 0, hr MAX_HR -> 0.
  - Dec: 0 -> 59 (sec/min), 0 -> MAX_HR (hr).
  - No carry into neighbouring fields.
- Start edge in IDLE or any SET_* state:
  - Preset non-zero: tm_en = 1 for exactly one cycle (the cycle after the edge), state -> RUN, busy = 1 from that same cycle.
  - Preset all zero: edge is ignored, no tm_en, state unchanged.
- init_* hold stable from the tm_en cycle through RUN and ALARM. They keep their value after the run, so the same preset can be relaunched.
- RUN: all button edges are ignored. timer_done high (level) moves to ALARM next cycle; busy = 0, alarm = 1.
- ALARM: leaves to IDLE after ALARM_CYCLES cycles, or on any button edge, whichever comes first. That button edge is consumed and has no other action. alarm goes to 0 on entry to IDLE.
- timer_done outside RUN is ignored.
- Same-cycle priority: start > mode > inc/dec.
  - Inc and dec edges together: no change.
  - Mode with inc/dec: the field changes, the value does not.
- Reset asserted mid-operation (including during the tm_en cycle): next cycle all outputs are 0 and state is IDLE. Any pending strobe is dropped.
- tm_en never asserts on two consecutive cycles.

Optional Feature:
- Macro: TIMER_PRESET_AUTOREPEAT_EN.
- Defined:
  - Holding btn_inc or btn_dec in a SET_* state gives the edge step.
  - After the level has been high for REPEAT_DLY cycles, one additional step follows every REPEAT_RATE cycles, with the same wrap rules.
  - The repeat counter clears when the button is released, the field changes, or the state leaves SET_*.
  - Inc and dec held together: no repeat.
- Not defined: one step per rising edge only, and the repeat counter logic is absent.

Test Plan:
- Reset, then mode x3, inc x5 -> edit_field 3, init_sec = 5; start edge -> tm_en high exactly one cycle, busy = 1, init_* = 0/0/5.
- SET_SEC with sec = 0, dec -> 59; SET_HR with hr = 23, inc -> 0; SET_MIN with min = 59, inc -> 0 and hr unchanged.
- All-zero preset, start edge -> no tm_en, state IDLE; then set sec = 1, start -> tm_en pulse.
- In RUN, press inc/mode -> no change; timer_done high -> alarm = 1 next cycle, busy = 0; no button press -> alarm clears after 10 cycles; a button edge during ALARM -> alarm clears the next cycle.
- Inc and dec edges in the same cycle -> value unchanged; mode and start in the same cycle -> tm_en issued, edit_field 0.
- Assert rst on the cycle after a start edge -> tm_en 0 and all outputs 0 the next cycle; button held through reset -> no action after release of rst.

Source files
------------

// File: rtl/timer_preset_if.sv
// Load interface between the time-entry controller (master) and the countdown timer (slave).
// Handshake: tm_en is a one-cycle load strobe with no ready/back-pressure; init_* are valid
// and stable in the tm_en cycle and afterwards, and timer_done is a level driven by the timer.
interface timer_preset_if;
    logic [4:0] init_hr;
    logic [5:0] init_min;
    logic [5:0] init_sec;
    logic       tm_en;
    logic       timer_done;

    modport master (
        output init_hr,
        output init_min,
        output init_sec,
        output tm_en,
        input  timer_done
    );

    modport slave (
        input  init_hr,
        input  init_min,
        input  init_sec,
        input  tm_en,
        output timer_done
    );
endinterface

// File: rtl/timer_preset.sv
// Time-entry and load controller: button edges edit an hr/min/sec preset and launch the timer.
// Optional hold-to-repeat on inc/dec is compiled in with TIMER_PRESET_AUTOREPEAT_EN.
module timer_preset #(
    parameter int MAX_HR       = 23,
    parameter int ALARM_CYCLES = 10,
    parameter int REPEAT_DLY   = 4,
    parameter int REPEAT_RATE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_mode,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic                  btn_start,
    timer_preset_if.master        tif,
    output logic [1:0]            edit_field,
    output logic                  busy,
    output logic                  alarm,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        RUN     = 3'd4,
        ALARM   = 3'd5
    } state_e;

    localparam int             ACW        = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_CYCLES - 1);
    localparam logic [5:0]     HR_MAX     = 6'(MAX_HR);
    localparam logic [5:0]     MS_MAX     = 6'd59;

    state_e         state, state_d;
    logic [4:0]     hr_q, hr_d;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
    logic           tm_en_q, tm_en_d;
    logic [ACW-1:0] acnt, acnt_d;
    logic [5:0]     hr_wide;

    // Bit order {start, dec, inc, mode}; history resets high so a held button gives no edge.
    logic [3:0] btn_lvl, btn_q, edge_r;
    logic       mode_e, inc_e, dec_e, start_e;
    logic       rep_up, rep_dn, step_up, step_dn, preset_nz;

    assign btn_lvl = {btn_start, btn_dec, btn_inc, btn_mode};
    assign mode_e  = edge_r[0];
    assign inc_e   = edge_r[1];
    assign dec_e   = edge_r[2];
    assign start_e = edge_r[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q  <= '1;
            edge_r <= '0;
        end else begin
            btn_q  <= btn_lvl;
            edge_r <= btn_lvl & ~btn_q;
        end
    end

`ifdef TIMER_PRESET_AUTOREPEAT_EN
    logic [7:0] rep_cnt, rate_cnt;
    logic       in_set, held_one, rep_clr, rep_fire;

    assign in_set   = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
    assign held_one = in_set && (btn_q[1] ^ btn_q[2]);
    assign rep_clr  = !held_one || mode_e || start_e;
    assign rep_fire = (rep_cnt == 8'(REPEAT_DLY)) && (rate_cnt == 8'd0) && !(inc_e || dec_e);
    assign rep_up   = rep_fire && btn_q[1];
    assign rep_dn   = rep_fire && btn_q[2];

    always_ff @(posedge clk) begin
        if (rst || rep_clr) begin
            rep_cnt  <= 8'd0;
            rate_cnt <= 8'd0;
        end else if (rep_cnt != 8'(REPEAT_DLY)) begin
            rep_cnt <= rep_cnt + 8'd1;
        end else begin
            rate_cnt <= (rate_cnt == 8'(REPEAT_RATE - 1)) ? 8'd0 : rate_cnt + 8'd1;
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
    // Repeat timing parameters only take effect when auto-repeat is compiled in.
    if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_unused
    end
`endif

    // Simultaneous inc and dec edges cancel out.
    assign step_up   = (inc_e && !dec_e) || rep_up;
    assign step_dn   = (dec_e && !inc_e) || rep_dn;
    assign preset_nz = |{hr_q, min_q, sec_q};

    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] vmax,
                                             input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up)      r = (v >= vmax) ? 6'd0 : v + 6'd1;
        else if (dn) r = (v == 6'd0) ? vmax : v - 6'd1;
        return r;
    endfunction

    always_comb begin
        state_d = state;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tm_en_d = 1'b0;
        acnt_d  = acnt;
        hr_wide = step_wrap({1'b0, hr_q}, HR_MAX, step_up, step_dn);
        case (state)
            IDLE, SET_HR, SET_MIN, SET_SEC: begin
                if (start_e && preset_nz) begin
                    state_d = RUN;
                    tm_en_d = 1'b1;
                end else if (mode_e) begin
                    case (state)
                        IDLE:    state_d = SET_HR;
                        SET_HR:  state_d = SET_MIN;
                        SET_MIN: state_d = SET_SEC;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    case (state)
                        SET_HR:  hr_d  = hr_wide[4:0];
                        SET_MIN: min_d = step_wrap(min_q, MS_MAX, step_up, step_dn);
                        SET_SEC: sec_d = step_wrap(sec_q, MS_MAX, step_up, step_dn);
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (tif.timer_done) begin
                    state_d = ALARM;
                    acnt_d  = '0;
                end
            end
            ALARM: begin
                // Any button edge silences the alarm and is otherwise consumed.
                if ((|edge_r) || (acnt == ALARM_LAST)) state_d = IDLE;
                else                                   acnt_d  = acnt + ACW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tm_en_q <= 1'b0;
            acnt    <= '0;
        end else begin
            state   <= state_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tm_en_q <= tm_en_d;
            acnt    <= acnt_d;
        end
    end

    assign tif.init_hr  = hr_q;
    assign tif.init_min = min_q;
    assign tif.init_sec = sec_q;
    assign tif.tm_en    = tm_en_q;
    assign state_dbg    = state;
    assign busy         = (state == RUN);
    assign alarm        = (state == ALARM);
    assign edit_field   = (state == SET_HR || state == SET_MIN || state == SET_SEC)
                          ? state_dbg[1:0] : 2'd0;

endmodule
